// File: rtl/lifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lifo_pkg : shared state type and sizing defaults for the bridge  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package lifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LIFO_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_out_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lifo_out_buf : 2-entry valid/ready FIFO carrying {last,data}     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lifo_out_buf
  import lifo_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             deq;

  assign valid   = (count != 2'd0);
  assign deq     = valid && rd_ready;
  assign rd_data = mem[rd_ptr];

  // The controller never writes when full, so capture and dequeue may coincide freely.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= !wr_ptr;
      end
      if (deq) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, wr_en} - {1'b0, deq};
    end
  end

endmodule
`default_nettype wire

// File: rtl/lifo_stream_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lifo_stream_bridge : stream -> LIFO push, drain -> popped stream |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lifo_stream_bridge
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LIFO_DEPTH = LIFO_DEPTH_DEF,
  parameter int CNT_W      = cnt_width(LIFO_DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  drain_req,
  input  logic [CNT_W-1:0]      drain_count,
  output logic                  busy,
  output logic                  drain_done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  lifo_push,
  output logic                  lifo_pop,
  output logic [DATA_WIDTH-1:0] lifo_din,
  input  logic [DATA_WIDTH-1:0] lifo_dout,
  input  logic                  lifo_full,
  input  logic                  lifo_empty
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        occ, remaining, take;
  logic                    inflight, inflight_last;
  logic                    accept, pop, finish, deq;
  logic                    buf_valid, buf_last;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic [1:0]              buf_count;
  logic [2:0]              buf_after;

  // Stack flags are only observed externally; occupancy is tracked locally.
  logic unused_stack_flags;
  assign unused_stack_flags = &{1'b0, lifo_full, lifo_empty};

  assign take      = (drain_count == '0 || drain_count > occ) ? occ : drain_count;
  assign deq       = buf_valid && m_ready;
  // Occupancy the buffer will hold after this edge; counting the dequeue keeps one pop per cycle.
  assign buf_after = 3'(buf_count) + 3'(inflight) - 3'(deq);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    accept   = 1'b0;
    pop      = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = !Rst && (occ < DEPTH_C) && !drain_req;
        if (!Rst && drain_req) begin
          if (take == '0) finish = 1'b1;
          else begin
            accept   = 1'b1;
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        pop = (remaining != '0) && (buf_after < 3'd2);
        if (pop && remaining == ONE_C) state_nx = FLUSH;
      end
      FLUSH: begin
        if (buf_after == 3'd0) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      occ           <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      drain_done    <= 1'b0;
    end else begin
      inflight      <= pop;
      inflight_last <= pop && (remaining == ONE_C);
      drain_done    <= finish;
      if (lifo_push)  occ <= occ + ONE_C;
      else if (pop)   occ <= occ - ONE_C;
      if (accept)     remaining <= take;
      else if (pop)   remaining <= remaining - ONE_C;
    end
  end

  lifo_out_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_out_buf (
    .Clk      (Clk),
    .Rst      (Rst),
    .wr_en    (inflight),
    .wr_data  ({inflight_last, lifo_dout}),
    .rd_ready (m_ready),
    .valid    (buf_valid),
    .rd_data  ({buf_last, buf_data}),
    .count    (buf_count)
  );

  assign busy      = (state != IDLE);
  assign lifo_push = s_valid && s_ready;
  assign lifo_din  = lifo_push ? s_data : '0;
  assign lifo_pop  = pop;
  assign m_valid   = buf_valid;
  assign m_data    = buf_valid ? buf_data : '0;
  assign m_last    = buf_valid && buf_last;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stream_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lifo_stream_bridge : bridge + behavioural 8x16 stack, checked |
// | against a queue-based reference model. Rev 1.0                   |
// +------------------------------------------------------------------+
module tb_lifo_stream_bridge;
  import lifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          drain_req;
  logic [CW-1:0] drain_count;
  logic          busy, drain_done;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          lifo_push, lifo_pop;
  logic [DW-1:0] lifo_din, lifo_dout;
  logic          lifo_full, lifo_empty;

  always #5 Clk = ~Clk;

  lifo_stream_bridge #(.DATA_WIDTH(DW), .LIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .drain_req(drain_req), .drain_count(drain_count), .busy(busy), .drain_done(drain_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_din(lifo_din), .lifo_dout(lifo_dout),
    .lifo_full(lifo_full), .lifo_empty(lifo_empty)
  );

  // LIFO_memory stand-in: registered dataOut, valid one cycle after POP.
  logic [DW-1:0] stk [DEPTH];
  logic [4:0]    sp;
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sp        <= 5'd0;
      lifo_dout <= '0;
    end else if (lifo_push && sp < 5'd16) begin
      stk[sp[3:0]] <= lifo_din;
      sp           <= sp + 5'd1;
    end else if (lifo_pop && sp != 5'd0) begin
      lifo_dout <= stk[4'(sp - 5'd1)];
      sp        <= sp - 5'd1;
    end
  end
  assign lifo_empty = (sp == 5'd0);
  assign lifo_full  = (sp == 5'd16);

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stack contents and the words a drain must emit.
  logic [DW-1:0] model_stk [$];
  logic [DW:0]   exp_q [$];
  bit            m_busy, done_due, done_next, exp_sready;
  int            pops_left, outstanding, stall, n;
  int            cyc = 0;
  int            acc_cyc, done_cyc;
  logic [DW:0]   beats [$];
  int            beat_cyc [$];
  int            pops_total, valid_total, busy_total, done_total;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Rst) begin
      check("rst_outputs", 32'({s_ready, busy, drain_done, m_valid, m_last, lifo_push, lifo_pop, m_data, lifo_din}), 32'd0);
      model_stk.delete();
      exp_q.delete();
      m_busy = 0; done_due = 0; pops_left = 0; outstanding = 0; stall = 0;
    end else begin
      exp_sready = !m_busy && model_stk.size() < DEPTH && !drain_req;
      check("s_ready", 32'(s_ready), 32'(exp_sready));
      check("busy", 32'(busy), 32'(m_busy));
      check("drain_done", 32'(drain_done), 32'(done_due));
      check("lifo_push", 32'(lifo_push), 32'(s_valid && exp_sready));
      if (lifo_push) check("lifo_din", 32'(lifo_din), 32'(s_data));
      check("occ_flags", 32'({lifo_empty, lifo_full}), 32'({dut.occ == 5'd0, dut.occ == 5'd16}));
      if (lifo_pop) check("pop_allowed", 32'(pops_left > 0), 32'd1);
      check("outstanding_le2", 32'(outstanding <= 2), 32'd1);
      if (m_valid) begin
        if (exp_q.size() == 0) check("m_valid_spurious", 32'(m_valid), 32'd0);
        else                   check("m_word", 32'({m_last, m_data}), 32'(exp_q[0]));
      end
      if (m_busy && !m_valid && exp_q.size() > 0) stall++;
      else stall = 0;
      if (stall > 6) begin
        check("output_stall", 32'(stall), 32'd0);
        stall = 0;
      end
      pops_total  += int'(lifo_pop);
      valid_total += int'(m_valid);
      busy_total  += int'(busy);
      done_total  += int'(drain_done);
      if (drain_done) done_cyc = cyc;

      // Advance the model to the state after the coming edge.
      done_next = 0;
      if (lifo_push) model_stk.push_back(s_data);
      if (!m_busy && drain_req) begin
        acc_cyc = cyc;
        n = (drain_count == 0 || int'(drain_count) > model_stk.size()) ? model_stk.size() : int'(drain_count);
        if (n == 0) done_next = 1;
        else begin
          for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, model_stk.pop_back()});
          m_busy    = 1;
          pops_left = n;
        end
      end
      if (lifo_pop) begin
        pops_left--;
        outstanding++;
      end
      if (m_valid && m_ready && exp_q.size() > 0) begin
        beats.push_back({m_last, m_data});
        beat_cyc.push_back(cyc);
        outstanding--;
        if (exp_q[0][DW]) begin
          m_busy    = 0;
          done_next = 1;
        end
        void'(exp_q.pop_front());
      end
      done_due = done_next;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) begin
        tick();
        s_valid = 1'b0;
        return;
      end
      tick();
    end
    check("push_timeout", 32'd1, 32'd0);
    s_valid = 1'b0;
  endtask

  task automatic run_drain(input logic [CW-1:0] cnt, input bit rand_rdy);
    beats.delete();
    beat_cyc.delete();
    drain_req   = 1'b1;
    drain_count = cnt;
    tick();
    drain_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (drain_done) begin
        m_ready = 1'b1;
        tick();
        return;
      end
      if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("drain_timeout", 32'd1, 32'd0);
    m_ready = 1'b1;
  endtask

  int p0, v0, b0, d0;

  initial begin
    Rst = 1'b1; s_valid = 1'b0; s_data = '0; drain_req = 1'b0; drain_count = '0; m_ready = 1'b1;
    pops_total = 0; valid_total = 0; busy_total = 0; done_total = 0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    check("reset_s_ready", 32'(s_ready), 32'd1);
    check("reset_occ", 32'(dut.occ), 32'd0);
    tick();

    // Three words, full drain, m_ready held high.
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    run_drain(5'd0, 1'b0);
    check("t1_count", 32'(beats.size()), 32'd3);
    if (beats.size() == 3) begin
      check("t1_w0", 32'(beats[0]), 32'h033);
      check("t1_w1", 32'(beats[1]), 32'h022);
      check("t1_w2", 32'(beats[2]), 32'h111);
      check("t1_first_lat", 32'(beat_cyc[0] - acc_cyc), 32'd3);
      check("t1_back2back", 32'(beat_cyc[2] - beat_cyc[0]), 32'd2);
      check("t1_done_lat", 32'(done_cyc - beat_cyc[2]), 32'd1);
    end
    check("t1_occ", 32'(dut.occ), 32'd0);

    // Fill to 16; a 17th word must be held off.
    for (int i = 0; i < 16; i++) push_word(8'(i));
    check("t2_full_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1; s_data = 8'h99;
    for (int i = 0; i < 4; i++) begin
      #1 check("t2_no_push", 32'(lifo_push), 32'd0);
      tick();
    end
    s_valid = 1'b0;
    run_drain(5'd0, 1'b0);
    check("t2_count", 32'(beats.size()), 32'd16);
    if (beats.size() == 16) check("t2_first", 32'(beats[0]), 32'h00F);

    // Partial drain then remainder.
    for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
    run_drain(5'd2, 1'b0);
    check("t3_count", 32'(beats.size()), 32'd2);
    if (beats.size() == 2) begin
      check("t3_w0", 32'(beats[0]), 32'h0A4);
      check("t3_w1", 32'(beats[1]), 32'h1A3);
    end
    run_drain(5'd0, 1'b0);
    check("t3b_count", 32'(beats.size()), 32'd3);
    if (beats.size() == 3) check("t3b_last", 32'(beats[2]), 32'h1A0);

    // Eight words under random backpressure.
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    run_drain(5'd0, 1'b1);
    check("t4_count", 32'(beats.size()), 32'd8);

    // Drain request on an empty stack.
    p0 = pops_total; v0 = valid_total; b0 = busy_total; d0 = done_total;
    run_drain(5'd0, 1'b0);
    repeat (3) tick();
    check("t5_no_pop", 32'(pops_total - p0), 32'd0);
    check("t5_no_valid", 32'(valid_total - v0), 32'd0);
    check("t5_no_busy", 32'(busy_total - b0), 32'd0);
    check("t5_one_done", 32'(done_total - d0), 32'd1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 6; i++) push_word(8'h61 + 8'(i));
    beats.delete();
    drain_req = 1'b1; drain_count = 5'd0;
    tick();
    drain_req = 1'b0;
    for (int i = 0; i < 20 && beats.size() < 2; i++) tick();
    Rst = 1'b1;
    #1;
    check("t6_rst_now", 32'({s_ready, busy, drain_done, m_valid, m_last, lifo_push, lifo_pop, m_data, lifo_din}), 32'd0);
    @(posedge Clk); @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    check("t6_s_ready", 32'(s_ready), 32'd1);
    check("t6_occ", 32'(dut.occ), 32'd0);
    tick();
    push_word(8'hAA);
    run_drain(5'd0, 1'b0);
    check("t6_count", 32'(beats.size()), 32'd1);
    if (beats.size() == 1) check("t6_word", 32'(beats[0]), 32'h1AA);

    // Randomised mix of pushes, drains and backpressure.
    for (int i = 0; i < 600; i++) begin
      s_valid     = 1'($urandom_range(0, 1));
      s_data      = 8'($urandom);
      drain_req   = ($urandom_range(0, 7) == 0);
      drain_count = 5'($urandom_range(0, 18));
      m_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_valid = 1'b0; drain_req = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 100 && (busy || exp_q.size() > 0); i++) tick();
    repeat (2) tick();
    check("final_idle", 32'(busy), 32'd0);
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
